// File: rtl/rhythm_pkg.sv
// Shared definitions for the rhythm-game timing judge.
// Holds the judgment codes, point values and the datapath widths that the
// lane timers, the top level and the bus interface all agree on.
package rhythm_pkg;

    localparam int unsigned SCORE_W     = 16;
    localparam int unsigned COMBO_W     = 10;
    localparam int unsigned OFFSET_W    = 16;
    localparam int unsigned PTS_PERFECT = 3;
    localparam int unsigned PTS_GOOD    = 1;

    typedef enum logic [1:0] {
        JudgeNone    = 2'd0,
        JudgePerfect = 2'd1,
        JudgeGood    = 2'd2,
        JudgeMiss    = 2'd3
    } judge_e;

endpackage

// File: rtl/rhythm_judge_if.sv
// Bus between the chart/key front end and the timing judge.
// master: drives clear, key pulses and spawn pulses; receives judgments,
//         spawn drops, score and combo.
// slave:  the judge itself.
// o_Judge packs one 2-bit judge code per lane, lane n in bits [2n+1:2n].
interface rhythm_judge_if #(
    parameter int unsigned LANES = 4
);
    import rhythm_pkg::*;

    logic                   i_Clear;
    logic [LANES-1:0]       i_fPush;
    logic [LANES-1:0]       i_NoteSpawn;
    logic [LANES-1:0]       o_JudgeValid;
    logic [2*LANES-1:0]     o_Judge;
    logic [LANES-1:0]       o_SpawnDrop;
    logic [SCORE_W-1:0]     o_Score;
    logic [COMBO_W-1:0]     o_Combo;

    modport master (
        output i_Clear,
        output i_fPush,
        output i_NoteSpawn,
        input  o_JudgeValid,
        input  o_Judge,
        input  o_SpawnDrop,
        input  o_Score,
        input  o_Combo
    );

    modport slave (
        input  i_Clear,
        input  i_fPush,
        input  i_NoteSpawn,
        output o_JudgeValid,
        output o_Judge,
        output o_SpawnDrop,
        output o_Score,
        output o_Combo
    );

endinterface

// File: rtl/rhythm_lane_timer.sv
// One lane of the timing judge: tracks a single in-flight note and classifies
// key presses against its arrival time.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   clear_i         synchronous clear of the lane (highest priority)
//   tick_i          judge tick enable from the shared prescaler
//   push_i          one-cycle key pulse
//   spawn_i         one-cycle note spawn pulse
//   result_o        this cycle's judgment (combinational, feeds score/combo)
//   judge_valid_o   registered judgment strobe
//   judge_o         registered judgment code
//   spawn_drop_o    registered pulse for a rejected spawn
module rhythm_lane_timer
    import rhythm_pkg::*;
#(
    parameter int TRAVEL_TICKS = 1000,
    parameter int PERFECT_WIN  = 30,
    parameter int GOOD_WIN     = 80
) (
    input  logic   clk_i,
    input  logic   rst_ni,
    input  logic   clear_i,
    input  logic   tick_i,
    input  logic   push_i,
    input  logic   spawn_i,
    output judge_e result_o,
    output logic   judge_valid_o,
    output judge_e judge_o,
    output logic   spawn_drop_o
);

    typedef logic signed [OFFSET_W-1:0] offset_t;

    localparam offset_t Travel  = offset_t'(TRAVEL_TICKS);
    localparam offset_t PerfPos = offset_t'(PERFECT_WIN);
    localparam offset_t PerfNeg = offset_t'(-PERFECT_WIN);
    localparam offset_t GoodPos = offset_t'(GOOD_WIN);
    localparam offset_t GoodNeg = offset_t'(-GOOD_WIN);

    logic    pending_q;
    offset_t offset_q;
    logic    judge_valid_q;
    judge_e  judge_q;
    logic    drop_q;

    logic    in_good, in_perf, hit, expire, resolve, accept, drop;
    judge_e  result;

    // Offset counts down towards the judge line: positive is early, negative late.
    always_comb begin
        in_good = (offset_q <= GoodPos) && (offset_q >= GoodNeg);
        in_perf = (offset_q <= PerfPos) && (offset_q >= PerfNeg);
        hit     = pending_q && push_i && in_good;
        // A push on the expiring tick takes precedence over the miss.
        expire  = pending_q && tick_i && !hit && (offset_q == GoodNeg);
        resolve = hit || expire;
        // A note resolving this cycle frees the lane for a same-cycle spawn.
        accept  = spawn_i && (!pending_q || resolve);
        drop    = spawn_i && pending_q && !resolve;

        result = JudgeNone;
        if (!clear_i) begin
            if (hit) begin
                result = in_perf ? JudgePerfect : JudgeGood;
            end else if (expire) begin
                result = JudgeMiss;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending_q     <= 1'b0;
            offset_q      <= '0;
            judge_valid_q <= 1'b0;
            judge_q       <= JudgeNone;
            drop_q        <= 1'b0;
        end else if (clear_i) begin
            pending_q     <= 1'b0;
            offset_q      <= '0;
            judge_valid_q <= 1'b0;
            judge_q       <= JudgeNone;
            drop_q        <= 1'b0;
        end else begin
            pending_q <= accept || (pending_q && !resolve);
            if (accept) begin
                offset_q <= Travel;
            end else if (pending_q && tick_i && !resolve) begin
                offset_q <= offset_q - offset_t'(1);
            end
            judge_valid_q <= resolve;
            judge_q       <= result;
            drop_q        <= drop;
        end
    end

    assign result_o      = result;
    assign judge_valid_o = judge_valid_q;
    assign judge_o       = judge_q;
    assign spawn_drop_o  = drop_q;

endmodule

// File: rtl/rhythm_judge.sv
// Rhythm-game timing judge: classifies per-lane key pulses against note
// arrival times (PERFECT / GOOD / MISS) and accumulates score and combo.
// Ports:
//   i_Clk   system clock
//   i_Rst   asynchronous active-low reset
//   bus     rhythm_judge_if slave: clear, key and spawn pulses in;
//           judgments, spawn drops, saturating score and combo out.
module rhythm_judge
    import rhythm_pkg::*;
#(
    parameter int unsigned LANES        = 4,
    parameter int unsigned TICK_DIV     = 50_000,
    parameter int          TRAVEL_TICKS = 1000,
    parameter int          PERFECT_WIN  = 30,
    parameter int          GOOD_WIN     = 80
) (
    input  logic           i_Clk,
    input  logic           i_Rst,
    rhythm_judge_if.slave  bus
);

    localparam int unsigned PreW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned CntW      = $clog2(LANES + 1);
    localparam int unsigned ScoreSumW = SCORE_W + 1;
    localparam int unsigned ComboSumW = COMBO_W + 1;

    logic [PreW-1:0]    pre_q, pre_d;
    logic               tick;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [COMBO_W-1:0] combo_q, combo_d;

    judge_e             lane_res   [LANES];
    judge_e             lane_judge [LANES];
    logic [LANES-1:0]   judge_valid;
    logic [LANES-1:0]   spawn_drop;
    logic [2*LANES-1:0] judge_bus;

    logic [CntW-1:0]      n_perf, n_good;
    logic                 any_miss;
    logic [ScoreSumW-1:0] score_sum;
    logic [ComboSumW-1:0] combo_sum;

    always_comb begin
        tick  = (pre_q == PreW'(TICK_DIV - 1));
        pre_d = tick ? '0 : pre_q + 1'b1;
    end

    for (genvar n = 0; n < LANES; n++) begin : g_lane
        rhythm_lane_timer #(
            .TRAVEL_TICKS (TRAVEL_TICKS),
            .PERFECT_WIN  (PERFECT_WIN),
            .GOOD_WIN     (GOOD_WIN)
        ) u_lane (
            .clk_i         (i_Clk),
            .rst_ni        (i_Rst),
            .clear_i       (bus.i_Clear),
            .tick_i        (tick),
            .push_i        (bus.i_fPush[n]),
            .spawn_i       (bus.i_NoteSpawn[n]),
            .result_o      (lane_res[n]),
            .judge_valid_o (judge_valid[n]),
            .judge_o       (lane_judge[n]),
            .spawn_drop_o  (spawn_drop[n])
        );
    end

    // Score and combo use this cycle's unregistered results so they line up
    // with the registered judgment strobes.
    always_comb begin
        n_perf   = '0;
        n_good   = '0;
        any_miss = 1'b0;
        judge_bus = '0;
        for (int n = 0; n < LANES; n++) begin
            case (lane_res[n])
                JudgePerfect: n_perf = n_perf + 1'b1;
                JudgeGood:    n_good = n_good + 1'b1;
                JudgeMiss:    any_miss = 1'b1;
                default:      ;
            endcase
            judge_bus[2*n +: 2] = lane_judge[n];
        end

        score_sum = {1'b0, score_q}
                  + ScoreSumW'(n_perf) * ScoreSumW'(PTS_PERFECT)
                  + ScoreSumW'(n_good) * ScoreSumW'(PTS_GOOD);
        score_d   = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];

        combo_sum = {1'b0, combo_q} + ComboSumW'(n_perf) + ComboSumW'(n_good);
        if (any_miss) begin
            combo_d = '0;
        end else begin
            combo_d = combo_sum[COMBO_W] ? '1 : combo_sum[COMBO_W-1:0];
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            pre_q   <= '0;
            score_q <= '0;
            combo_q <= '0;
        end else if (bus.i_Clear) begin
            pre_q   <= '0;
            score_q <= '0;
            combo_q <= '0;
        end else begin
            pre_q   <= pre_d;
            score_q <= score_d;
            combo_q <= combo_d;
        end
    end

    assign bus.o_JudgeValid = judge_valid;
    assign bus.o_Judge      = judge_bus;
    assign bus.o_SpawnDrop  = spawn_drop;
    assign bus.o_Score      = score_q;
    assign bus.o_Combo      = combo_q;

endmodule

// File: doc/rhythm_judge.md
# rhythm_judge

Timing-judge stage for the rhythm game, directly downstream of the per-key one-push pulse generators. It takes one-cycle key pulses per lane and note-spawn pulses from the chart sequencer, and classifies each hit against the note's arrival time as PERFECT, GOOD or MISS. It also accumulates score and combo for the display stage.

## Interface
- LANES, 4: number of key lanes.
- TICK_DIV, 50_000: clock cycles per judge tick (1 ms at 50 MHz).
- TRAVEL_TICKS, 1000: ticks from spawn until the note reaches the judge line.
- PERFECT_WIN, 30: maximum |offset| in ticks for PERFECT.
- GOOD_WIN, 80: maximum |offset| in ticks for GOOD. Requires PERFECT_WIN ≤ GOOD_WIN < TRAVEL_TICKS.

Ports:
- i_Clk  in  1  system clock. One clock domain.
- i_Rst  in  1  reset, asynchronous, active-low.
- i_Clear  in  1  synchronous clear of notes, score and combo.
- i_fPush  in  LANES  one-cycle key-press pulses, active-high, already debounced.
- i_NoteSpawn  in  LANES  one-cycle pulse; a note starts travelling in that lane.
- o_JudgeValid  out  LANES  one-cycle pulse per lane when a judgment is issued.
- o_Judge  out  2*LANES  judgment code per lane (lane n in bits [2n+1:2n]), valid with o_JudgeValid.
- o_SpawnDrop  out  LANES  one-cycle pulse when a spawn is rejected.
- o_Score  out  16  accumulated score, saturating.
- o_Combo  out  10  consecutive non-MISS judgments, saturating.

## Operation
- Tick prescaler: a free-running counter from 0 to TICK_DIV-1. The tick enable is 1 for one cycle when the counter is at TICK_DIV-1.
- Each lane has a pending flag and a signed 16-bit offset.
  - Spawn accepted: pending becomes 1 and offset loads TRAVEL_TICKS.
  - On each tick while pending, offset decrements. Positive offset means early, negative means late.
- Push on a lane, evaluated on the pre-update offset:
  - Pending and |offset| ≤ PERFECT_WIN: PERFECT, pending cleared.
  - Pending and |offset| ≤ GOOD_WIN: GOOD, pending cleared.
  - Pending with offset > GOOD_WIN, or lane not pending: ignored. No result, no combo effect.
- Auto-miss: a tick while pending with offset = -GOOD_WIN produces MISS and clears pending. No further decrement happens.
- Push and expiring tick in the same cycle: the push wins and is judged GOOD or PERFECT on offset -GOOD_WIN.
- Spawn while pending: rejected and o_SpawnDrop pulses. Exception: if the pending note resolves (hit or miss) in the same cycle, the spawn is accepted and offset loads TRAVEL_TICKS.
- Judge codes, defined in the package: 0 NONE, 1 PERFECT, 2 GOOD, 3 MISS.
- Score per cycle: add 3 per PERFECT and 1 per GOOD across all lanes. Saturate at 16'hFFFF.
- Combo per cycle:
  - Any MISS in the cycle: combo becomes 0, even if other lanes hit.
  - Otherwise combo increases by the number of hits. Saturate at 1023.
- i_Clear: pending, offsets, score, combo and prescaler go to 0. No judgments are issued that cycle. i_Clear has priority over all inputs.

## Timing
- Registered outputs. A push, or a tick-triggered miss, at cycle t gives o_JudgeValid and o_Judge at t+1. o_Score and o_Combo reflect that judgment at t+1.
- A spawn at t gives pending=1 at t+1. A rejected spawn at t gives o_SpawnDrop at t+1.
- Reset values: o_JudgeValid=0, o_Judge=0, o_SpawnDrop=0, o_Score=0, o_Combo=0. Internal pending flags and prescaler are also 0.
- Reset asserted mid-flight discards all pending notes with no MISS issued.
- Lanes are fully independent. Any subset may issue results in the same cycle.

## Structure
- Shared package rhythm_pkg:
  - judge codes NONE/PERFECT/GOOD/MISS
  - point values PTS_PERFECT=3, PTS_GOOD=1
  - SCORE_W=16, COMBO_W=10, OFFSET_W=16
- Sub-module rhythm_lane_timer, instantiated LANES times. It holds pending, offset, window compare, and the spawn/drop and judge outputs for one lane.
- Top level holds the prescaler, score/combo adder-reduction and saturation.

## Test plan
- Reset, then idle for 5 ticks -> all outputs 0, no JudgeValid.
- Test parameters: TICK_DIV=4, TRAVEL_TICKS=100, PERFECT_WIN=3, GOOD_WIN=8.
  - Spawn lane 0, push at offset 2 -> lane 0 PERFECT one cycle after push; score 3, combo 1.
  - Same parameters, push at offset -6 -> GOOD; score +1.
- Spawn lane 1, no push -> MISS on the tick where offset is -8; combo 0.
  - Push on the same cycle as that tick -> GOOD instead, no MISS.
- Push with no pending note, then push at offset 50 -> no JudgeValid; note still pending.
- Spawn lane 2 twice, 10 ticks apart -> second gives SpawnDrop.
  - Spawn in the same cycle as the first note's hit -> accepted, no drop.
- Lanes 0 (PERFECT) and 3 (MISS) resolve in the same cycle -> score +3, combo 0.
  - Preloaded score 65534 plus a PERFECT -> saturates to 65535.
